// File: rtl/oflow_wb_pkg.sv
// Shared sizing, state encoding and remainder helpers for the object-feature
// write-back scheduler.
package oflow_wb_pkg;

    localparam int unsigned PE_NUM          = 24;
    localparam int unsigned ROW_NUM         = 4;
    localparam int unsigned HIST_FRAMES     = 5;

    localparam int unsigned GROUPS          = PE_NUM / 4;
    localparam int unsigned MAX_OBJ         = PE_NUM * ROW_NUM;
    localparam int unsigned WORDS_PER_FRAME = MAX_OBJ / 2;
    localparam int unsigned OBJ_W           = $clog2(MAX_OBJ + 1);
    localparam int unsigned ADDR_W          = $clog2(HIST_FRAMES * WORDS_PER_FRAME);
    localparam int unsigned SLOT_W          = $clog2(HIST_FRAMES);
    localparam int unsigned GROUP_W         = $clog2(GROUPS);
    localparam int unsigned ROW_W           = $clog2(ROW_NUM);
    localparam int unsigned BEAT_W          = $clog2(MAX_OBJ / 4 + 1);
    localparam int unsigned REM_W           = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE
    } wb_state_e;

    // Remainder 0 encodes a full beat of four objects.
    localparam logic [REM_W-1:0] REM_FULL = '0;

    // Word 1 carries objects 2..3 of the beat; it holds data for 3 or 4 objects.
    function automatic logic word1_valid(input logic [REM_W-1:0] rem);
        return (rem == REM_FULL) || (rem == REM_W'(3));
    endfunction

endpackage

// File: rtl/oflow_mem_wb_scheduler_if.sv
// Core-FSM handshake plus mem/PE select and MEM buffer write-port bundle.
interface oflow_mem_wb_scheduler_if;
    import oflow_wb_pkg::*;

    logic                start;
    logic [OBJ_W-1:0]    num_objects;
    logic [SLOT_W-1:0]   frame_slot;
    logic                mem_ready;
    logic                busy;
    logic                done;
    logic [GROUP_W-1:0]  pe_sel;
    logic [ROW_W-1:0]    row_sel;
    logic [REM_W-1:0]    remainder;
    logic                we_0;
    logic                we_1;
    logic [ADDR_W-1:0]   addr_0;
    logic [ADDR_W-1:0]   addr_1;

    modport master (
        output start, num_objects, frame_slot, mem_ready,
        input  busy, done, pe_sel, row_sel, remainder, we_0, we_1, addr_0, addr_1
    );

    modport slave (
        input  start, num_objects, frame_slot, mem_ready,
        output busy, done, pe_sel, row_sel, remainder, we_0, we_1, addr_0, addr_1
    );

endinterface

// File: rtl/oflow_wb_beat_counter.sv
// Nested PE-group / row counters for the next beat to issue, plus its linear index.
module oflow_wb_beat_counter
    import oflow_wb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [GROUP_W-1:0] pe,
    output logic [ROW_W-1:0]   row,
    output logic [BEAT_W-1:0]  beat
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe   <= '0;
            row  <= '0;
            beat <= '0;
        end else if (clear) begin
            pe   <= '0;
            row  <= '0;
            beat <= '0;
        end else if (advance) begin
            beat <= beat + BEAT_W'(1);
            if (pe == GROUP_W'(GROUPS - 1)) begin
                pe  <= '0;
                row <= row + ROW_W'(1);
            end else begin
                pe  <= pe + GROUP_W'(1);
            end
        end
    end

endmodule

// File: rtl/oflow_mem_wb_scheduler.sv
// Write-back sequencer: one registered beat per ready cycle, four objects per
// beat, two buffer words per beat, framed by a start/busy/done handshake.
module oflow_mem_wb_scheduler
    import oflow_wb_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    oflow_mem_wb_scheduler_if.slave  wb
);

    wb_state_e           state, state_n;
    logic                busy_q, busy_n, done_q, done_n;
    logic                we0_q, we0_n, we1_q, we1_n;
    logic [GROUP_W-1:0]  pe_q, pe_n;
    logic [ROW_W-1:0]    row_q, row_n;
    logic [REM_W-1:0]    rem_q, rem_n;
    logic [ADDR_W-1:0]   addr0_q, addr0_n, addr1_q, addr1_n;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_n;
    logic [BEAT_W-1:0]   last_idx_q, last_idx_n;
    logic [REM_W-1:0]    rem_last_q, rem_last_n;

    logic                issue;
    logic [GROUP_W-1:0]  cnt_pe;
    logic [ROW_W-1:0]    cnt_row;
    logic [BEAT_W-1:0]   cnt_beat;

    logic [SLOT_W-1:0]   slot_c;
    logic [ADDR_W-1:0]   base_c, src_addr;
    logic [OBJ_W:0]      obj_round_c;
    logic [BEAT_W-1:0]   last_idx_c, src_last_idx;
    logic [REM_W-1:0]    src_rem;
    logic                idle_c;

    oflow_wb_beat_counter u_beat_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_DONE),
        .advance (issue),
        .pe      (cnt_pe),
        .row     (cnt_row),
        .beat    (cnt_beat)
    );

    // Request decode: out-of-range slots fall back to slot 0; beats = ceil(n/4).
    always_comb begin
        slot_c      = (wb.frame_slot < SLOT_W'(HIST_FRAMES)) ? wb.frame_slot : '0;
        base_c      = ADDR_W'(slot_c) * ADDR_W'(WORDS_PER_FRAME);
        obj_round_c = {1'b0, wb.num_objects} + (OBJ_W + 1)'(3);
        last_idx_c  = BEAT_W'(obj_round_c >> 2) - BEAT_W'(1);
        idle_c      = (state == ST_IDLE);
        // Beat 0 is issued straight from IDLE so it appears the cycle after start.
        src_addr     = idle_c ? base_c : next_addr_q;
        src_last_idx = idle_c ? last_idx_c : last_idx_q;
        src_rem      = idle_c ? wb.num_objects[REM_W-1:0] : rem_last_q;
    end

    always_comb begin
        state_n     = state;
        busy_n      = busy_q;
        done_n      = 1'b0;
        we0_n       = 1'b0;
        we1_n       = 1'b0;
        pe_n        = pe_q;
        row_n       = row_q;
        rem_n       = rem_q;
        addr0_n     = addr0_q;
        addr1_n     = addr1_q;
        next_addr_n = next_addr_q;
        last_idx_n  = last_idx_q;
        rem_last_n  = rem_last_q;
        issue       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (wb.start) begin
                    busy_n      = 1'b1;
                    last_idx_n  = last_idx_c;
                    rem_last_n  = wb.num_objects[REM_W-1:0];
                    next_addr_n = base_c;
                    if (wb.num_objects == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_WRITE;
                        issue   = wb.mem_ready;
                    end
                end
            end
            ST_WRITE: begin
                if (cnt_beat > last_idx_q) begin
                    state_n = ST_DONE;
                end else begin
                    issue = wb.mem_ready;
                end
            end
            ST_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // A stalled cycle leaves select/remainder/address registers untouched.
        if (issue) begin
            we0_n       = 1'b1;
            rem_n       = (cnt_beat == src_last_idx) ? src_rem : REM_FULL;
            we1_n       = word1_valid(rem_n);
            pe_n        = cnt_pe;
            row_n       = cnt_row;
            addr0_n     = src_addr;
            addr1_n     = src_addr + ADDR_W'(1);
            next_addr_n = src_addr + ADDR_W'(2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we0_q       <= 1'b0;
            we1_q       <= 1'b0;
            pe_q        <= '0;
            row_q       <= '0;
            rem_q       <= '0;
            addr0_q     <= '0;
            addr1_q     <= '0;
            next_addr_q <= '0;
            last_idx_q  <= '0;
            rem_last_q  <= '0;
        end else begin
            state       <= state_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            we0_q       <= we0_n;
            we1_q       <= we1_n;
            pe_q        <= pe_n;
            row_q       <= row_n;
            rem_q       <= rem_n;
            addr0_q     <= addr0_n;
            addr1_q     <= addr1_n;
            next_addr_q <= next_addr_n;
            last_idx_q  <= last_idx_n;
            rem_last_q  <= rem_last_n;
        end
    end

    assign wb.busy      = busy_q;
    assign wb.done      = done_q;
    assign wb.we_0      = we0_q;
    assign wb.we_1      = we1_q;
    assign wb.pe_sel    = pe_q;
    assign wb.row_sel   = row_q;
    assign wb.remainder = rem_q;
    assign wb.addr_0    = addr0_q;
    assign wb.addr_1    = addr1_q;

endmodule

// File: tb/tb_oflow_mem_wb_scheduler.sv
// Directed bench for the write-back scheduler: vector table plus stall, reset
// and start-while-busy sequences.
module tb_oflow_mem_wb_scheduler;
    import oflow_wb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    oflow_mem_wb_scheduler_if bus ();

    oflow_mem_wb_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int n;
        int slot;
        int beats;
        int last_rem;
        int last_we1;
        int last_addr1;
        int done_cyc;
        int poke;
    } vec_t;

    vec_t vecs[9];

    // Expected per-cycle trace for n=12, slot 1, mem_ready low for edges 1..3.
    int st_we0  [8] = '{1, 0, 0, 0, 1, 1, 0, 0};
    int st_addr0[8] = '{48, 48, 48, 48, 50, 52, 52, 52};
    int st_pe   [8] = '{0, 0, 0, 0, 1, 2, 2, 2};
    int st_done [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int st_busy [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_we0"}, int'(bus.we_0), 0);
        check({tag, "_we1"}, int'(bus.we_1), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, beats, done_cyc, lrem, lwe1, la1, er, ew1, slot_eff, a0;
        string tag;
        tag = $sformatf("v%0d", idx);
        slot_eff = (v.slot >= int'(HIST_FRAMES)) ? 0 : v.slot;
        bus.num_objects = OBJ_W'(v.n);
        bus.frame_slot  = SLOT_W'(v.slot);
        bus.mem_ready   = 1'b1;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        beats = 0; done_cyc = -1; lrem = 0; lwe1 = 0; la1 = 0;
        check({tag, "_busy_c1"}, int'(bus.busy), 1);
        while (cyc < 60 && done_cyc < 0) begin
            if (bus.done) begin
                done_cyc = cyc;
                check({tag, "_busy_at_done"}, int'(bus.busy), 0);
            end else if (bus.we_0) begin
                er  = (beats == v.beats - 1) ? (v.n % 4) : 0;
                ew1 = (er == 0 || er == 3) ? 1 : 0;
                a0  = slot_eff * int'(WORDS_PER_FRAME) + 2 * beats;
                check({tag, "_pe"},    int'(bus.pe_sel),    beats % int'(GROUPS));
                check({tag, "_row"},   int'(bus.row_sel),   beats / int'(GROUPS));
                check({tag, "_addr0"}, int'(bus.addr_0),    a0);
                check({tag, "_addr1"}, int'(bus.addr_1),    a0 + 1);
                check({tag, "_rem"},   int'(bus.remainder), er);
                check({tag, "_we1"},   int'(bus.we_1),      ew1);
                lrem = int'(bus.remainder);
                lwe1 = int'(bus.we_1);
                la1  = int'(bus.addr_1);
                beats++;
            end
            // Optional stray start while busy, with different request fields.
            bus.start = (cyc == v.poke) ? 1'b1 : 1'b0;
            if (cyc == v.poke) begin
                bus.num_objects = OBJ_W'(96);
                bus.frame_slot  = SLOT_W'(3);
            end
            if (done_cyc < 0) begin
                tick();
                cyc++;
            end
        end
        bus.start = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, v.done_cyc);
        check({tag, "_beats"},      beats,    v.beats);
        check({tag, "_last_rem"},   lrem,     v.last_rem);
        check({tag, "_last_we1"},   lwe1,     v.last_we1);
        check({tag, "_last_addr1"}, la1,      v.last_addr1);
        tick();
        check_quiet({tag, "_after"});
    endtask

    initial begin
        int cyc, we_count, done_count;

        //         n  slot beats rem we1 addr1 done poke
        vecs[0] = '{8,  0, 2,  0, 1, 3,   4,  0};
        vecs[1] = '{7,  2, 2,  3, 1, 99,  4,  0};
        vecs[2] = '{6,  2, 2,  2, 0, 99,  4,  0};
        vecs[3] = '{0,  1, 0,  0, 0, 0,   2,  0};
        vecs[4] = '{96, 4, 24, 0, 1, 239, 26, 0};
        vecs[5] = '{5,  7, 2,  1, 0, 3,   4,  0};
        vecs[6] = '{1,  3, 1,  1, 0, 145, 3,  0};
        vecs[7] = '{8,  0, 2,  0, 1, 3,   4,  1};
        vecs[8] = '{12, 1, 3,  0, 1, 53,  5,  3};

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.num_objects = '0;
        bus.frame_slot  = '0;
        bus.mem_ready   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_quiet("reset");
        check("reset_addr0", int'(bus.addr_0), 0);
        check("reset_addr1", int'(bus.addr_1), 0);
        check("reset_pe",    int'(bus.pe_sel), 0);
        check("reset_rem",   int'(bus.remainder), 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // Stall on beat 1 for three cycles.
        bus.num_objects = OBJ_W'(12);
        bus.frame_slot  = SLOT_W'(1);
        bus.mem_ready   = 1'b1;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("stall_c%0d_we0", c),   int'(bus.we_0),   st_we0[c-1]);
            check($sformatf("stall_c%0d_we1", c),   int'(bus.we_1),   st_we0[c-1]);
            check($sformatf("stall_c%0d_addr0", c), int'(bus.addr_0), st_addr0[c-1]);
            check($sformatf("stall_c%0d_pe", c),    int'(bus.pe_sel), st_pe[c-1]);
            check($sformatf("stall_c%0d_done", c),  int'(bus.done),   st_done[c-1]);
            check($sformatf("stall_c%0d_busy", c),  int'(bus.busy),   st_busy[c-1]);
            bus.mem_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
            tick();
        end
        bus.mem_ready = 1'b1;

        // Reset asserted while beat 2 of n=20 is on the bus.
        bus.num_objects = OBJ_W'(20);
        bus.frame_slot  = SLOT_W'(0);
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("rst_mid_beat2_addr0", int'(bus.addr_0), 4);
        #1 reset = 1'b1;
        #1;
        check_quiet("rst_mid_now");
        check("rst_mid_addr0", int'(bus.addr_0), 0);
        check("rst_mid_pe",    int'(bus.pe_sel), 0);
        tick();
        reset = 1'b0;
        we_count = 0;
        done_count = 0;
        cyc = 0;
        while (cyc < 12) begin
            we_count   += int'(bus.we_0) + int'(bus.we_1);
            done_count += int'(bus.done);
            tick();
            cyc++;
        end
        check("rst_mid_no_we",   we_count,   0);
        check("rst_mid_no_done", done_count, 0);
        check_quiet("rst_mid_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oflow_mem_wb_scheduler.md
Name: oflow_mem_wb_scheduler

Overview:
- Sequences write-back of per-object feature vectors from the PE array into the MEM buffer through the mem/PE interface.
- Each beat steps pe_sel (group of 4 PEs), row_sel and remainder, and drives two buffer word write-enables and addresses.
- Sits between core FSM (start/done handshake) and the mem/PE interface plus MEM buffer write ports.
- One beat moves 4 objects as 2 buffer words of 2 features each.

Parameters:
- PE_NUM, 24, number of PEs; must be a multiple of 4.
- ROW_NUM, 4, object rows held per PE.
- HIST_FRAMES, 5, history frame slots in MEM buffer.
- Derived (localparam): GROUPS=PE_NUM/4; MAX_OBJ=PE_NUM*ROW_NUM; WORDS_PER_FRAME=MAX_OBJ/2; OBJ_W=$clog2(MAX_OBJ+1); ADDR_W=$clog2(HIST_FRAMES*WORDS_PER_FRAME).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request from core FSM; sampled only in IDLE.
- num_objects  in  OBJ_W  objects in current frame, 0..MAX_OBJ; latched on start.
- frame_slot  in  $clog2(HIST_FRAMES)  target history slot; latched on start.
- mem_ready  in  1  buffer accepts writes this cycle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- pe_sel  out  $clog2(GROUPS)  PE group for current beat.
- row_sel  out  $clog2(ROW_NUM)  PE row for current beat.
- remainder  out  2  valid objects in beat: 0 means 4, else 1..3.
- we_0  out  1  write enable, buffer word 0.
- we_1  out  1  write enable, buffer word 1.
- addr_0  out  ADDR_W  address of word 0.
- addr_1  out  ADDR_W  address of word 1.

Behaviour:
- Reset: state=IDLE. All outputs 0. Counters and latches cleared. Reset mid-operation aborts immediately: no done, no further we.
- FSM states: IDLE, WRITE, DONE.
- IDLE + start:
  - Latch num_objects and frame_slot; beat=0.
  - Go to DONE if num_objects==0, else WRITE.
  - busy rises the next cycle.
- WRITE, one beat b per cycle while mem_ready=1:
  - row_sel=b/GROUPS; pe_sel=b%GROUPS (counters, no divider).
  - Beat b carries objects 4b..4b+3.
  - last_beat = (b == ceil(num_objects/4)-1).
  - remainder = last_beat ? num_objects[1:0] : 0.
  - we_0=1. we_1=1 only when remainder is 0 or 3.
  - addr_0 = frame_slot*WORDS_PER_FRAME + 2b; addr_1 = addr_0+1.
  - Last beat: go to DONE.
- mem_ready=0 in WRITE:
  - we_0=we_1=0.
  - pe_sel, row_sel, remainder and addresses hold.
  - Beat does not advance; no beat is lost or repeated.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then return to IDLE.
- Latency:
  - First write beat in the cycle after start.
  - Total cycles with no stalls = 1 + ceil(n/4) + 1.
  - n=0 completes in 2 cycles with no writes.
- start while busy is ignored; latched values are not disturbed.
- Addresses never exceed HIST_FRAMES*WORDS_PER_FRAME-1. frame_slot>=HIST_FRAMES is treated as slot 0.
- All outputs are registered. we/addr/sel change only on clk.

Decomposition:
- Shared package oflow_wb_pkg holds:
  - state enum (IDLE, WRITE, DONE).
  - derived localparams: GROUPS, MAX_OBJ, WORDS_PER_FRAME, widths.
  - remainder encoding.
- Optional sub-module oflow_wb_beat_counter: nested pe_sel/row_sel counters with wrap, plus the linear beat index.
- FSM and address generation stay in the top module.

Test Plan:
1. n=8, slot=0, mem_ready=1 → 2 beats.
   - (pe_sel,row_sel)=(0,0),(1,0).
   - remainder 0,0; we_0=we_1=1 both beats.
   - addr_0=0,2.
   - done at cycle 4 after start.
2. n=7, slot=2 → beat1: remainder=3, we_1=1; addr_0=98, addr_1=99. n=6 variant: remainder=2, we_1=0.
3. n=0 → no we asserted; done pulse in cycle 2; busy high for exactly one cycle.
4. n=96, slot=4 → 24 beats.
   - pe_sel wraps 5→0 and row_sel increments at beats 6, 12, 18.
   - Final addr_1=239.
   - Finishing with remainder=0 and we_1=1 confirms the full last beat is written.
5. n=12, mem_ready low at beat1 for 3 cycles → we low, outputs frozen; beat1 issued once after release; done delayed by 3 cycles.
6. Assert reset at beat2 of n=20 → outputs 0 immediately, no done. start during busy in a separate run → ignored, original n completes.
